// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the round-robin arbiter
package arb_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/dec3to8_onehot.sv
// rtl/dec3to8_onehot.sv - 3-bit index to 8-bit one-hot decode, forced to zero when not valid
module dec3to8_onehot
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             valid_i,
  output logic [NREQ-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      onehot_o[i] = valid_i && (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with grant holding and max-hold timeout
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX < 1) ? 0 : HOLD_MAX - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  // Scan from the far end of the rotation back to ptr so the nearest request wins.
  always_comb begin
    win_idx = ptr_q;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDX_W'(k);
      if (req[cand]) begin
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d = GRANT;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q] || ((HOLD_MAX != 0) && (cnt_q == CNT_LAST))) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = req[idx_q];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  dec3to8_onehot u_dec (
    .idx_i    (idx_d),
    .valid_i  (state_d == GRANT),
    .onehot_o (gnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - scoreboard bench for rr_arbiter8 with HOLD_MAX=4
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    int idx;
    int gap;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   to_q[$];
  exp_t cur;
  bit   have_cur;
  bit   prev_valid;
  bit   done;
  int   idle_cnt;
  int   len_cnt;
  int   last_idx;
  int   checks;
  int   errors;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic push(input int idx, input int gap, input int len);
    exp_t e;
    e.idx = idx;
    e.gap = gap;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Negedge k happens at time 10*k; inputs change there, DUT samples them at 10*k+5.
  task automatic at_neg(input int k);
    while ($time < 64'(k * 10)) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after every clock edge or reset assertion.
  always begin
    @(posedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk(gnt == 8'h00, "reset_gnt", int'(gnt), 0);
      chk(gnt_idx == 3'd0, "reset_gnt_idx", int'(gnt_idx), 0);
      chk(gnt_valid == 1'b0, "reset_gnt_valid", int'(gnt_valid), 0);
      chk(timeout == 1'b0, "reset_timeout", int'(timeout), 0);
      prev_valid = 1'b0;
      have_cur   = 1'b0;
      idle_cnt   = 0;
      len_cnt    = 0;
    end else begin
      chk($onehot0(gnt), "gnt_onehot0", int'(gnt), 0);
      chk(gnt_valid == (|gnt), "gnt_valid_vs_gnt", int'(gnt_valid), int'(|gnt));
      if (gnt_valid) begin
        chk(gnt == 8'(1 << gnt_idx), "gnt_vs_idx", int'(gnt), 1 << gnt_idx);
      end
      if (timeout) begin
        chk(to_q.size() != 0, "timeout_expected", 1, 0);
        if (to_q.size() != 0) begin
          int e;
          e = to_q.pop_front();
          chk(!gnt_valid, "timeout_gnt_valid", int'(gnt_valid), 0);
          chk(last_idx == e, "timeout_idx", last_idx, e);
        end
      end
      if (gnt_valid && !prev_valid) begin
        chk(exp_q.size() != 0, "grant_expected", int'(gnt_idx), -1);
        if (exp_q.size() != 0) begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          chk(int'(gnt_idx) == cur.idx, "grant_idx", int'(gnt_idx), cur.idx);
          chk(gnt == 8'(1 << cur.idx), "grant_vec", int'(gnt), 1 << cur.idx);
          if (cur.gap >= 0) chk(idle_cnt == cur.gap, "idle_gap", idle_cnt, cur.gap);
        end
        idle_cnt = 0;
        len_cnt  = 0;
        last_idx = int'(gnt_idx);
      end
      if (gnt_valid) len_cnt++;
      else idle_cnt++;
      if (!gnt_valid && prev_valid && have_cur) begin
        if (cur.len >= 0) chk(len_cnt == cur.len, "grant_len", len_cnt, cur.len);
        have_cur = 1'b0;
      end
      prev_valid = gnt_valid;
    end
    if (done) begin
      chk(exp_q.size() == 0, "grants_outstanding", exp_q.size(), 0);
      chk(to_q.size() == 0, "timeouts_outstanding", to_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, expected finish near time 700");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; done = 1'b0; have_cur = 1'b0;
    prev_valid = 1'b0; idle_cnt = 0; len_cnt = 0; last_idx = 0;
    en = 1'b1; req = 8'h00; rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset release, idle with no requests, then a lone request from index 4.
    at_neg(2);  rst_n = 1'b1;
    at_neg(5);  req = 8'h10; push(4, -1, 2);
    at_neg(7);  req = 8'h00;

    // Fresh reset so rotation starts at ptr=0.
    at_neg(8);  rst_n = 1'b0;
    at_neg(9);  rst_n = 1'b1;

    // Rotation: all request, each grantee drops for one cycle after 2 cycles of grant.
    at_neg(10); req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      push(g % 8, (g == 0) ? -1 : 1, 2);
      at_neg(12 + 3 * g);
      if (g == 8) req = 8'h00;
      else req[g % 8] = 1'b0;
      if (g != 8) begin
        at_neg(13 + 3 * g);
        req[g % 8] = 1'b1;
      end
    end

    // Enable gating: en dropped mid-grant does not revoke; no new grant until en returns.
    at_neg(37); req = 8'h04; push(2, 1, 3);
    at_neg(38); en = 1'b0;
    at_neg(39); req = 8'hFF;
    at_neg(40); req = 8'hFB;
    at_neg(41); req = 8'hFF;
    at_neg(44); en = 1'b1; push(3, 4, 1);
    at_neg(45); req = 8'h00;

    // Timeout: index 0 held past HOLD_MAX=4, then index 2 wins.
    at_neg(46); req = 8'h05; push(0, 1, 4); to_q.push_back(0); push(2, 1, 1);
    at_neg(52); req = 8'h00;

    // Wrap and skip: grant 6 leaves ptr=7, then 0 wins, then 1 even with 0 re-requesting.
    at_neg(53); req = 8'h40; push(6, 1, 1);
    at_neg(54); req = 8'h00;
    at_neg(55); req = 8'h03; push(0, 1, 1);
    at_neg(56); req = 8'h02;
    at_neg(57); req = 8'h03; push(1, 1, 1);
    at_neg(58); req = 8'h00;

    // Async reset mid-grant to index 5 with ptr=7; after reset 5 must beat 7.
    at_neg(59); req = 8'h40; push(6, 1, 1);
    at_neg(60); req = 8'h00;
    at_neg(61); req = 8'h20; push(5, 1, -1);
    at_neg(62); #2 rst_n = 1'b0;
    at_neg(63); rst_n = 1'b1; req = 8'hA0; push(5, -1, 1);
    at_neg(64); req = 8'h00;
    at_neg(66); done = 1'b1;
  end

endmodule
